// File: rtl/adder_sequencer.sv
// Sequencer for the 32-bit adder lab: captures operands, adds byte-serially with a
// rippled carry, then hands the peripherals over to result display.
module adder_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enterpulse,
  input  logic                restart,
  input  logic                inputdata_ready,
  input  logic [8*NBYTES-1:0] dataA,
  input  logic [8*NBYTES-1:0] dataB,
  output logic                loaddata,
  output logic                clearinputs,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] dataR,
  output logic                carry,
  output logic [1:0]          state
);

  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned W    = 8 * NBYTES;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StAdd  = 2'd1,
    StShow = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic            c_q, c_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            clear_q, clear_d;
  logic            first_q, first_d;

  logic [7:0]      a_byte, b_byte;
  logic [8:0]      sum;

  // The peripheral unit owns enterpulse; nothing here reacts to it.
  logic            unused_enterpulse;
  assign unused_enterpulse = enterpulse;

  always_comb begin
    a_byte = 8'd0;
    b_byte = 8'd0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (idx_q == IdxW'(k)) begin
        a_byte = a_q[8*k +: 8];
        b_byte = b_q[8*k +: 8];
      end
    end
    sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, c_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    clear_d = 1'b0;
    first_d = 1'b0;

    case (state_q)
      StLoad: begin
        // A stale ready can linger while clearinputs is still in flight.
        if (inputdata_ready && !clear_q) begin
          a_d     = dataA;
          b_d     = dataB;
          r_d     = '0;
          c_d     = 1'b0;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int k = 0; k < int'(NBYTES); k++) begin
          if (idx_q == IdxW'(k)) begin
            r_d[8*k +: 8] = sum[7:0];
          end
        end
        c_d = sum[8];
        if (idx_q == IdxW'(NBYTES - 1)) begin
          carry_d = sum[8];
          idx_d   = '0;
          first_d = 1'b1;
          state_d = StShow;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StShow: begin
        if (restart) begin
          clear_d = 1'b1;
          state_d = StLoad;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      clear_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      clear_q <= clear_d;
      first_q <= first_d;
    end
  end

  assign loaddata    = (state_q != StShow);
  assign busy        = (state_q == StAdd);
  assign done        = (state_q == StShow) && first_q;
  assign state       = state_q;
  assign clearinputs = clear_q;
  assign dataR       = r_q;
  assign carry       = carry_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer: vector table of operand pairs plus hand-written
// sequences for restart, clear blocking, mid-ADD reset and operand changes after capture.
module tb_adder_sequencer;

  logic        clk;
  logic        reset;
  logic        enterpulse;
  logic        restart;
  logic        inputdata_ready;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        loaddata;
  logic        clearinputs;
  logic        busy;
  logic        done;
  logic [31:0] dataR;
  logic        carry;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  adder_sequencer #(.NBYTES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .enterpulse      (enterpulse),
    .restart         (restart),
    .inputdata_ready (inputdata_ready),
    .dataA           (dataA),
    .dataB           (dataB),
    .loaddata        (loaddata),
    .clearinputs     (clearinputs),
    .busy            (busy),
    .done            (done),
    .dataR           (dataR),
    .carry           (carry),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Low bytes of a ripple-carry sum equal the low bits of the full-width sum.
  function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b,
                                          input int k);
    logic [32:0] full;
    logic [31:0] mask;
    full = {1'b0, a} + {1'b0, b};
    mask = (k >= 3) ? 32'hFFFF_FFFF : ((32'h1 << (8 * (k + 1))) - 32'h1);
    return full[31:0] & mask;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec);
    dataA           = a;
    dataB           = b;
    inputdata_ready = 1'b1;
    step();
    inputdata_ready = 1'b0;
    chk("cap_state", 64'(state), 64'd1);
    chk("cap_busy", 64'(busy), 64'd1);
    chk("cap_loaddata", 64'(loaddata), 64'd1);
    chk("cap_dataR_zero", 64'(dataR), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("add_partial", 64'(dataR), 64'(partial(a, b, k)));
      if (k < 3) begin
        chk("add_busy", 64'(busy), 64'd1);
        chk("add_done_low", 64'(done), 64'd0);
      end else begin
        chk("show_state", 64'(state), 64'd2);
        chk("show_done", 64'(done), 64'd1);
        chk("show_loaddata", 64'(loaddata), 64'd0);
        chk("show_busy", 64'(busy), 64'd0);
        chk("show_carry", 64'(carry), 64'(ec));
        chk("show_dataR", 64'(dataR), 64'(er));
      end
    end
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("show_hold_dataR", 64'(dataR), 64'(er));
    chk("show_hold_carry", 64'(carry), 64'(ec));
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rst_state_load", 64'(state), 64'd0);
    chk("rst_clear_high", 64'(clearinputs), 64'd1);
    step();
    chk("rst_clear_low", 64'(clearinputs), 64'd0);
  endtask

  initial begin
    vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, r: 32'h0000_0100, c: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, r: 32'h0000_0000, c: 1'b1};
    vecs[2] = '{a: 32'h1234_5678, b: 32'h9ABC_DEF0, r: 32'hACF1_3568, c: 1'b0};

    reset           = 1'b0;
    enterpulse      = 1'b0;
    restart         = 1'b0;
    inputdata_ready = 1'b0;
    dataA           = '0;
    dataB           = '0;
    #12;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_loaddata", 64'(loaddata), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_clear", 64'(clearinputs), 64'd0);
    chk("reset_dataR", 64'(dataR), 64'd0);
    chk("reset_carry", 64'(carry), 64'd0);
    reset = 1'b1;
    step();

    // restart in LOAD is ignored
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("load_restart_state", 64'(state), 64'd0);
    chk("load_restart_clear", 64'(clearinputs), 64'd0);

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c);
      do_restart();
    end

    // restart during ADD is ignored
    dataA = 32'h0000_0010; dataB = 32'h0000_0020; inputdata_ready = 1'b1;
    step();
    inputdata_ready = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("add_restart_state", 64'(state), 64'd1);
    chk("add_restart_clear", 64'(clearinputs), 64'd0);
    step(); step(); step();
    chk("add_restart_show", 64'(state), 64'd2);
    chk("add_restart_result", 64'(dataR), 64'h30);

    // restart+enterpulse in SHOW, ready held high through the clearinputs cycle
    restart = 1'b1; enterpulse = 1'b1; inputdata_ready = 1'b1;
    dataA = 32'h0000_0001; dataB = 32'h0000_0002;
    step();
    restart = 1'b0; enterpulse = 1'b0;
    chk("both_state_load", 64'(state), 64'd0);
    chk("both_clear", 64'(clearinputs), 64'd1);
    chk("both_dataR_hold", 64'(dataR), 64'h30);
    step();
    chk("blocked_state", 64'(state), 64'd0);
    chk("blocked_clear_low", 64'(clearinputs), 64'd0);
    step();
    inputdata_ready = 1'b0;
    chk("late_capture_state", 64'(state), 64'd1);
    // change operands mid-ADD; result must use the captured values
    dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
    step(); step(); step(); step();
    chk("captured_result", 64'(dataR), 64'h3);
    chk("captured_carry", 64'(carry), 64'd0);
    do_restart();

    // reset asserted during the second ADD cycle
    dataA = 32'h1111_1111; dataB = 32'h2222_2222; inputdata_ready = 1'b1;
    step();
    inputdata_ready = 1'b0;
    step();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("pre_reset_partial", 64'(dataR), 64'h33);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_loaddata", 64'(loaddata), 64'd1);
    chk("async_done", 64'(done), 64'd0);
    chk("async_dataR", 64'(dataR), 64'd0);
    #3;
    reset = 1'b1;
    step();
    chk("post_reset_state", 64'(state), 64'd0);
    chk("post_reset_dataR", 64'(dataR), 64'd0);
    chk("post_reset_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Controller that sequences the 32-bit adder lab datapath. It keeps the peripheral unit in operand-load mode until all eight operand bytes are entered, then captures A and B. It computes R = A + B byte-serially over four cycles with a rippled carry, and switches the peripherals to result-display mode. A restart request clears the peripheral input index and begins a new operation. It sits between the peripheral unit (enter pulse, operand bytes, display) and the result path that drives `dataR`.

## Interface
Parameters:
- NBYTES, 4, number of operand/result bytes; operand width is 8*NBYTES.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enterpulse  in  1  one-cycle enter pulse from the peripheral pulse generator.
- restart  in  1  one-cycle request to start a new operation.
- inputdata_ready  in  1  high when the peripheral unit holds all 2*NBYTES operand bytes.
- dataA  in  8*NBYTES  operand A from the peripheral unit.
- dataB  in  8*NBYTES  operand B from the peripheral unit.
- loaddata  out  1  1 selects peripheral load mode; 0 selects result-display mode.
- clearinputs  out  1  one-cycle pulse that clears the peripheral input/output indexes.
- busy  out  1  high while the addition is in progress.
- done  out  1  one-cycle pulse on the first cycle in SHOW.
- dataR  out  8*NBYTES  result register.
- carry  out  1  carry-out of the most significant byte.
- state  out  2  encoded state: LOAD=0, ADD=1, SHOW=2 (3 unused).

## Operation
- Reset (reset=0), asynchronous:
  - state=LOAD, loaddata=1, clearinputs=0, busy=0, done=0.
  - dataR=0, carry=0, internal A/B copies=0, byte index=0, carry register=0.
- LOAD:
  - loaddata=1.
  - On an edge with inputdata_ready=1:
    - latch dataA/dataB into internal registers;
    - clear dataR to 0 and the carry register to 0;
    - set byte index to 0;
    - go to ADD.
  - enterpulse is ignored by this block in LOAD; the peripheral unit consumes it.
- ADD:
  - busy=1 and loaddata=1, so the display keeps showing the input view.
  - On each edge, byte k of the result is computed as {c, dataR[8k+7:8k]} = A[8k+7:8k] + B[8k+7:8k] + c_reg. This is a 9-bit sum.
  - The new c becomes c_reg, and k increments.
  - After byte NBYTES-1 is written: carry = c, k resets to 0, go to SHOW.
  - Bytes not yet computed read 0 in dataR.
- SHOW:
  - loaddata=0, busy=0.
  - done=1 for exactly the first SHOW cycle.
  - dataR and carry hold.
  - enterpulse scrolls the peripheral display; the block takes no action on it.
  - restart=1: go to LOAD and assert clearinputs=1 for the following single cycle. dataR and carry hold until the next capture.
- restart in LOAD or ADD is ignored, and does not generate clearinputs.
- Internal A/B copies are used during ADD. Changes on dataA/dataB after capture do not affect the result.
- Illegal state encoding (3) returns to LOAD on the next edge.

## Timing
- Let T0 be the edge on which LOAD sees inputdata_ready=1.
  - After T0: state=ADD, busy=1.
  - Byte k is written on edge T0+1+k, so byte NBYTES-1 lands on T0+NBYTES.
  - After T0+NBYTES: state=SHOW, busy=0, done=1, loaddata=0, carry valid.
  - After T0+NBYTES+1: done=0.
  - Capture-to-result latency is NBYTES+1 edges, which is 5 with the default.
- inputdata_ready already high on the first LOAD cycle after reset or restart: capture on that edge. No minimum dwell is required.
- If clearinputs has not yet propagated, inputdata_ready may still be high during the first LOAD cycle after restart. Capture is therefore blocked while clearinputs=1. The earliest capture is the edge after clearinputs falls.
- restart and enterpulse on the same SHOW edge: restart wins.
- All outputs are registered, except the Moore decodes of state: loaddata, busy, done, state.
- Reset mid-ADD: returns to LOAD immediately with a partial dataR cleared to 0. No done pulse is generated.

## Test plan
- Reset, then A=0x000000FF, B=0x00000001 with ready=1:
  - ADD lasts 4 cycles, busy=1 for all 4;
  - then dataR=0x00000100, carry=0;
  - done is high for 1 cycle and loaddata falls with it.
- A=0xFFFFFFFF, B=0x00000001 -> dataR=0x00000000, carry=1; byte-by-byte, dataR bytes go 0x00 each cycle. Repeat with A=0x12345678, B=0x9ABCDEF0 -> dataR=0xACF13568, carry=0.
- In SHOW, pulse restart:
  - state=LOAD;
  - clearinputs=1 for exactly 1 cycle;
  - no capture while ready stays high during the clearinputs cycle;
  - capture on the next edge with ready=1.
- restart during LOAD and during ADD -> no state change, clearinputs stays 0. restart and enterpulse together in SHOW -> LOAD with clearinputs pulse.
- Assert reset=0 at the second ADD cycle:
  - all outputs are at reset values immediately, without waiting for clk;
  - after release, state=LOAD and dataR=0.
- Change dataA/dataB mid-ADD -> result matches the operands captured at T0.
